// File: rtl/jt6295_chseq_if.sv
`default_nettype none
// ============================================================================
//  Module      : jt6295_chseq_if
//  Description : Bundle between the 6295 controller, ROM port and ADPCM
//                decoder on one side and the channel sequencer on the other.
//  Revision    : 1.0  initial release
// ============================================================================
interface jt6295_chseq_if;
    logic        cen4;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [17:0] start_addr;
    logic [17:0] stop_addr;
    logic [3:0]  att;
    logic [3:0]  busy;
    logic [3:0]  ack;
    logic        zero;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        nib_vld;
    logic [1:0]  nib_ch;
    logic [3:0]  nib_data;
    logic [3:0]  nib_att;
    logic        nib_first;

    // Environment side: controller, ROM and decoder
    modport master (
        output cen4, start, stop, start_addr, stop_addr, att, rom_data, rom_ok,
        input  busy, ack, zero, rom_addr, nib_vld, nib_ch, nib_data, nib_att, nib_first
    );

    // Sequencer side
    modport slave (
        input  cen4, start, stop, start_addr, stop_addr, att, rom_data, rom_ok,
        output busy, ack, zero, rom_addr, nib_vld, nib_ch, nib_data, nib_att, nib_first
    );
endinterface
`default_nettype wire

// File: rtl/jt6295_chseq.sv
`default_nettype none
// ============================================================================
//  Module      : jt6295_chseq
//  Description : Four-channel time-multiplexed ADPCM address sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module jt6295_chseq (
    input  wire logic      clk,
    input  wire logic      rst,
    jt6295_chseq_if.slave  bus
);
    localparam int c_NCH = 4;

    logic [1:0]  r_slot_q,     w_slot_d;
    logic [17:0] r_cur_addr_q [c_NCH];
    logic [17:0] w_cur_addr_d [c_NCH];
    logic [17:0] r_end_addr_q [c_NCH];
    logic [17:0] w_end_addr_d [c_NCH];
    logic [3:0]  r_catt_q     [c_NCH];
    logic [3:0]  w_catt_d     [c_NCH];
    logic [3:0]  r_lsb_q,      w_lsb_d;
    logic [3:0]  r_first_q,    w_first_d;
    logic [3:0]  r_busy_q,     w_busy_d;
    logic [3:0]  r_ack_q,      w_ack_d;
    logic        r_zero_q,     w_zero_d;
    logic        r_nib_vld_q,  w_nib_vld_d;
    logic [1:0]  r_nib_ch_q,   w_nib_ch_d;
    logic [3:0]  r_nib_data_q, w_nib_data_d;
    logic [3:0]  r_nib_att_q,  w_nib_att_d;
    logic        r_nib_first_q, w_nib_first_d;

    // Only the channel owning the closing slot is evaluated on each cen4.
    always_comb begin
        w_slot_d      = r_slot_q;
        w_cur_addr_d  = r_cur_addr_q;
        w_end_addr_d  = r_end_addr_q;
        w_catt_d      = r_catt_q;
        w_lsb_d       = r_lsb_q;
        w_first_d     = r_first_q;
        w_busy_d      = r_busy_q;
        w_ack_d       = 4'd0;
        w_zero_d      = 1'b0;
        w_nib_vld_d   = 1'b0;
        w_nib_ch_d    = r_nib_ch_q;
        w_nib_data_d  = r_nib_data_q;
        w_nib_att_d   = r_nib_att_q;
        w_nib_first_d = r_nib_first_q;

        if (bus.cen4) begin
            w_slot_d = r_slot_q + 2'd1;
            w_zero_d = (r_slot_q == 2'd3);

            if (bus.start[r_slot_q]) begin
                w_cur_addr_d[r_slot_q] = bus.start_addr;
                w_end_addr_d[r_slot_q] = bus.stop_addr;
                w_catt_d[r_slot_q]     = bus.att;
                w_lsb_d[r_slot_q]      = 1'b0;
                w_first_d[r_slot_q]    = 1'b1;
                w_busy_d[r_slot_q]     = 1'b1;
                w_ack_d[r_slot_q]      = 1'b1;
            end else if (bus.stop[r_slot_q]) begin
                w_busy_d[r_slot_q] = 1'b0;
            end else if (r_busy_q[r_slot_q] && bus.rom_ok) begin
                w_nib_vld_d   = 1'b1;
                w_nib_ch_d    = r_slot_q;
                w_nib_data_d  = r_lsb_q[r_slot_q] ? bus.rom_data[3:0] : bus.rom_data[7:4];
                w_nib_att_d   = r_catt_q[r_slot_q];
                w_nib_first_d = r_first_q[r_slot_q];
                w_first_d[r_slot_q] = 1'b0;
                w_lsb_d[r_slot_q]   = ~r_lsb_q[r_slot_q];
                // Byte fully consumed: finish on the inclusive end byte, else step (wraps at 2^18)
                if (r_lsb_q[r_slot_q]) begin
                    if (r_cur_addr_q[r_slot_q] == r_end_addr_q[r_slot_q]) begin
                        w_busy_d[r_slot_q] = 1'b0;
                    end else begin
                        w_cur_addr_d[r_slot_q] = r_cur_addr_q[r_slot_q] + 18'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_q      <= 2'd0;
            for (int i = 0; i < c_NCH; i++) begin
                r_cur_addr_q[i] <= 18'd0;
                r_end_addr_q[i] <= 18'd0;
                r_catt_q[i]     <= 4'd0;
            end
            r_lsb_q       <= 4'd0;
            r_first_q     <= 4'd0;
            r_busy_q      <= 4'd0;
            r_ack_q       <= 4'd0;
            r_zero_q      <= 1'b0;
            r_nib_vld_q   <= 1'b0;
            r_nib_ch_q    <= 2'd0;
            r_nib_data_q  <= 4'd0;
            r_nib_att_q   <= 4'd0;
            r_nib_first_q <= 1'b0;
        end else begin
            r_slot_q      <= w_slot_d;
            r_cur_addr_q  <= w_cur_addr_d;
            r_end_addr_q  <= w_end_addr_d;
            r_catt_q      <= w_catt_d;
            r_lsb_q       <= w_lsb_d;
            r_first_q     <= w_first_d;
            r_busy_q      <= w_busy_d;
            r_ack_q       <= w_ack_d;
            r_zero_q      <= w_zero_d;
            r_nib_vld_q   <= w_nib_vld_d;
            r_nib_ch_q    <= w_nib_ch_d;
            r_nib_data_q  <= w_nib_data_d;
            r_nib_att_q   <= w_nib_att_d;
            r_nib_first_q <= w_nib_first_d;
        end
    end

    assign bus.busy      = r_busy_q;
    assign bus.ack       = r_ack_q;
    assign bus.zero      = r_zero_q;
    assign bus.rom_addr  = r_cur_addr_q[r_slot_q];
    assign bus.nib_vld   = r_nib_vld_q;
    assign bus.nib_ch    = r_nib_ch_q;
    assign bus.nib_data  = r_nib_data_q;
    assign bus.nib_att   = r_nib_att_q;
    assign bus.nib_first = r_nib_first_q;
endmodule
`default_nettype wire

// File: tb/tb_jt6295_chseq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt6295_chseq
//  Description : Directed, table-driven bench for the ADPCM channel sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jt6295_chseq;
    typedef struct {
        logic [1:0]  ch;
        logic [3:0]  data;
        logic [3:0]  att;
        logic        first;
        logic [17:0] addr;
    } nib_t;

    typedef struct {
        int          ch;
        logic [17:0] saddr;
        logic [17:0] eaddr;
        logic [3:0]  att;
        int          n;
        logic [31:0] nibs;   // nibble i at [4*i +: 4]
    } vec_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          n_cmp;
    int          n_err;
    logic [17:0] last_addr;
    nib_t        cap_q[$];
    int          ack_q[$];
    vec_t        vecs[4];

    jt6295_chseq_if bus();

    jt6295_chseq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [17:0] a);
        case (a)
            18'h00100: rom_byte = 8'hA5;
            18'h00101: rom_byte = 8'h3C;
            18'h3FFFF: rom_byte = 8'h12;
            18'h00000: rom_byte = 8'h34;
            default:   rom_byte = a[7:0] + 8'h5A;
        endcase
    endfunction

    always_comb bus.rom_data = rom_byte(bus.rom_addr);

    // cen4 high for one clk in every four
    initial begin
        int k;
        k = 0;
        bus.cen4 = 1'b0;
        forever begin
            @(negedge clk);
            k = (k + 1) % 4;
            bus.cen4 = (k == 0);
        end
    end

    // Address presented during the slot that produced the next nibble
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.cen4) last_addr <= bus.rom_addr;
    end

    always @(negedge clk) begin
        if (bus.nib_vld)
            cap_q.push_back('{ch: bus.nib_ch, data: bus.nib_data, att: bus.nib_att,
                              first: bus.nib_first, addr: last_addr});
        for (int b = 0; b < 4; b++)
            if (bus.ack[b]) ack_q.push_back(b);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %0s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_ack(input int ch);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ack[ch] && n < 40);
        check("ack_seen", {31'd0, bus.ack[ch]}, 32'd1);
        bus.start[ch] = 1'b0;
    endtask

    task automatic wait_idle(input int ch, input int budget);
        int n;
        n = 0;
        while (bus.busy[ch] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop", {31'd0, bus.busy[ch]}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] nb;
        logic [17:0] ea;
        int          t0;
        cyc = 0;
        n_cmp = 0;
        n_err = 0;
        last_addr = 18'd0;

        vecs[0] = '{ch: 2, saddr: 18'h00100, eaddr: 18'h00101, att: 4'h3, n: 4, nibs: 32'h0000C35A};
        vecs[1] = '{ch: 3, saddr: 18'h3FFFF, eaddr: 18'h00000, att: 4'h7, n: 4, nibs: 32'h00004321};
        vecs[2] = '{ch: 0, saddr: 18'h00200, eaddr: 18'h00202, att: 4'hF, n: 6, nibs: 32'h00C5B5A5};
        vecs[3] = '{ch: 1, saddr: 18'h00150, eaddr: 18'h00150, att: 4'h0, n: 2, nibs: 32'h000000AA};

        rst = 1'b1;
        bus.start = 4'd0;
        bus.stop = 4'd0;
        bus.start_addr = 18'd0;
        bus.stop_addr = 18'd0;
        bus.att = 4'd0;
        bus.rom_ok = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {28'd0, bus.busy}, 32'd0);
        check("rst_ack", {28'd0, bus.ack}, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd0);
        check("rst_nib_vld", {31'd0, bus.nib_vld}, 32'd0);
        rst = 1'b0;

        // zero period with cen4 every 4 clks
        t0 = 0;
        for (int n = 0; n < 40 && !bus.zero; n++) @(negedge clk);
        t0 = cyc;
        @(negedge clk);
        for (int n = 0; n < 40 && !bus.zero; n++) @(negedge clk);
        check("zero_period", cyc - t0, 32'd16);

        // single-channel phrase table
        for (int v = 0; v < 4; v++) begin
            cap_q.delete();
            bus.start_addr = vecs[v].saddr;
            bus.stop_addr  = vecs[v].eaddr;
            bus.att        = vecs[v].att;
            bus.start[vecs[v].ch] = 1'b1;
            wait_ack(vecs[v].ch);
            wait_idle(vecs[v].ch, 400);
            check("vec_count", cap_q.size(), vecs[v].n);
            nb = vecs[v].nibs;
            for (int i = 0; i < vecs[v].n && i < cap_q.size(); i++) begin
                ea = vecs[v].saddr + 18'(i / 2);
                check("vec_data", {28'd0, cap_q[i].data}, {28'd0, nb[4*i +: 4]});
                check("vec_ch", {30'd0, cap_q[i].ch}, vecs[v].ch);
                check("vec_att", {28'd0, cap_q[i].att}, {28'd0, vecs[v].att});
                check("vec_first", {31'd0, cap_q[i].first}, (i == 0) ? 32'd1 : 32'd0);
                check("vec_addr", {14'd0, cap_q[i].addr}, {14'd0, ea});
            end
        end

        // rom_ok stall on ch1 for two rounds
        cap_q.delete();
        bus.start_addr = 18'h00200;
        bus.stop_addr  = 18'h00200;
        bus.att        = 4'h5;
        bus.start[1]   = 1'b1;
        wait_ack(1);
        bus.rom_ok = 1'b0;
        repeat (32) @(negedge clk);
        check("stall_no_nib", cap_q.size(), 32'd0);
        check("stall_busy", {31'd0, bus.busy[1]}, 32'd1);
        bus.rom_ok = 1'b1;
        wait_idle(1, 200);
        check("stall_count", cap_q.size(), 32'd2);
        if (cap_q.size() == 2) begin
            check("stall_nib0", {28'd0, cap_q[0].data}, 32'h5);
            check("stall_first", {31'd0, cap_q[0].first}, 32'd1);
            check("stall_addr", {14'd0, cap_q[0].addr}, 32'h200);
            check("stall_nib1", {28'd0, cap_q[1].data}, 32'hA);
        end

        // start beats simultaneous stop; held stop then ends the channel silently
        cap_q.delete();
        bus.start[0] = 1'b1;
        bus.stop[0]  = 1'b1;
        wait_ack(0);
        check("startstop_busy", {31'd0, bus.busy[0]}, 32'd1);
        wait_idle(0, 40);
        check("startstop_no_nib", cap_q.size(), 32'd0);
        bus.stop[0] = 1'b0;

        // all four channels at once
        cap_q.delete();
        ack_q.delete();
        bus.start_addr = 18'h00100;
        bus.stop_addr  = 18'h00101;
        bus.att        = 4'h9;
        bus.start      = 4'hF;
        for (int n = 0; n < 80 && bus.start != 4'd0; n++) begin
            @(negedge clk);
            bus.start = bus.start & ~bus.ack;
        end
        check("all_start_dropped", {28'd0, bus.start}, 32'd0);
        for (int n = 0; n < 400 && bus.busy != 4'd0; n++) @(negedge clk);
        check("all_busy_drop", {28'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("all_acks", ack_q.size(), 32'd4);
        check("all_count", cap_q.size(), 32'd16);
        if (ack_q.size() == 4 && cap_q.size() == 16) begin
            nb = 32'h0000C35A;
            for (int i = 1; i < 4; i++)
                check("ack_order", ack_q[i], (ack_q[i-1] + 1) % 4);
            for (int i = 0; i < 16; i++) begin
                check("all_ch", {30'd0, cap_q[i].ch}, (ack_q[0] + i) % 4);
                check("all_data", {28'd0, cap_q[i].data}, {28'd0, nb[4*(i/4) +: 4]});
                check("all_first", {31'd0, cap_q[i].first}, (i < 4) ? 32'd1 : 32'd0);
            end
        end

        // reset in the middle of a long phrase
        cap_q.delete();
        bus.start_addr = 18'h00000;
        bus.stop_addr  = 18'h000FF;
        bus.start[2]   = 1'b1;
        wait_ack(2);
        repeat (40) @(negedge clk);
        check("rst_mid_playing", {31'd0, (cap_q.size() > 0)}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", {28'd0, bus.busy}, 32'd0);
        check("rst_mid_ack", {28'd0, bus.ack}, 32'd0);
        check("rst_mid_nib_vld", {31'd0, bus.nib_vld}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
